// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, decoder encodings, control word layout
// and the ID/EX register update actions.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_R     = 2'b00;
    localparam logic [1:0] ALUOP_I     = 2'b01;
    localparam logic [1:0] ALUOP_LSB   = 2'b10;
    localparam logic [1:0] ALUOP_OTHER = 2'b11;

    localparam logic [1:0] WB_IMM = 2'b00;
    localparam logic [1:0] WB_PC4 = 2'b01;
    localparam logic [1:0] WB_ALU = 2'b10;
    localparam logic [1:0] WB_DM  = 2'b11;

    // The nine decoder outputs carried from ID to EX.
    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] dm_to_reg;
        logic       reg_write;
        logic       dm_en;
        logic       dm_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic       auipc;
    } ctrl_t;

    // Control word of a bubble: no architectural side effects.
    localparam ctrl_t BUBBLE_CTRL = '{
        alu_op:    ALUOP_OTHER,
        dm_to_reg: WB_IMM,
        reg_write: 1'b0,
        dm_en:     1'b0,
        dm_write:  1'b0,
        jump:      1'b0,
        branch:    1'b0,
        alu_src:   1'b1,
        auipc:     1'b0
    };

    // What the ID/EX register does on the next edge.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_LOAD   = 2'd2
    } ex_action_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently sitting in EX.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_dm_en,
    input  logic       ex_dm_write,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [6:0] id_op,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hazard
);

    logic rs1_used_s;
    logic rs2_used_s;
    logic ex_load_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    // Decode which source fields the ID opcode really reads.
    always_comb begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
        case (id_op)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                rs1_used_s = 1'b0;
                rs2_used_s = 1'b0;
            end
            OP_R, OP_STORE, OP_BRANCH: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
            end
            default: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b0;
            end
        endcase
    end

    // Hazard equation; x0 as load destination never matches.
    always_comb begin
        ex_load_s = ex_valid & ex_dm_en & ~ex_dm_write & ex_reg_write & (ex_rd != 5'd0);
        rs1_hit_s = rs1_used_s & (id_rs1 == ex_rd);
        rs2_hit_s = rs2_used_s & (id_rs2 == ex_rd);
        hazard    = ex_load_s & id_valid & (rs1_hit_s | rs2_hit_s);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX redirect
// flush, downstream stall hold and a saturating bubble counter.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [6:0]      id_op,
    input  logic [1:0]      id_ALU_op,
    input  logic [1:0]      id_DMtoReg,
    input  logic            id_RegWrite,
    input  logic            id_DM_en,
    input  logic            id_DM_write,
    input  logic            id_jump,
    input  logic            id_branch,
    input  logic            id_ALU_src,
    input  logic            id_auipc,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic            ex_stall,
    input  logic            ex_redirect,
    output logic            ex_valid,
    output logic [1:0]      ex_ALU_op,
    output logic [1:0]      ex_DMtoReg,
    output logic            ex_RegWrite,
    output logic            ex_DM_en,
    output logic            ex_DM_write,
    output logic            ex_jump,
    output logic            ex_branch,
    output logic            ex_ALU_src,
    output logic            ex_auipc,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            hazard_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            ex_valid_r;
    ctrl_t           ex_ctrl_r;
    logic [XLEN-1:0] ex_pc_r, ex_rs1_data_r, ex_rs2_data_r, ex_imm_r;
    logic [4:0]      ex_rs1_r, ex_rs2_r, ex_rd_r;
    logic [2:0]      ex_funct3_r;
    logic            ex_funct7b5_r;
    logic [CNT_W-1:0] bubble_cnt_r;

    ctrl_t           id_ctrl_s;
    logic            hazard_s;
    ex_action_t      action_s;
    logic            count_inc_s;

    load_use_detect u_load_use_detect (
        .ex_valid     (ex_valid_r),
        .ex_dm_en     (ex_ctrl_r.dm_en),
        .ex_dm_write  (ex_ctrl_r.dm_write),
        .ex_reg_write (ex_ctrl_r.reg_write),
        .ex_rd        (ex_rd_r),
        .id_valid     (id_valid),
        .id_op        (id_op),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .hazard       (hazard_s)
    );

    // Pack decoder outputs; an empty ID slot carries the bubble control word.
    always_comb begin
        id_ctrl_s = BUBBLE_CTRL;
        if (id_valid) begin
            id_ctrl_s = '{
                alu_op:    id_ALU_op,
                dm_to_reg: id_DMtoReg,
                reg_write: id_RegWrite,
                dm_en:     id_DM_en,
                dm_write:  id_DM_write,
                jump:      id_jump,
                branch:    id_branch,
                alu_src:   id_ALU_src,
                auipc:     id_auipc
            };
        end else begin
            id_ctrl_s = BUBBLE_CTRL;
        end
    end

    // Select the register update: redirect beats stall beats hazard.
    always_comb begin
        action_s    = ACT_LOAD;
        count_inc_s = 1'b0;
        if (ex_redirect) begin
            action_s = ACT_BUBBLE;
        end else if (ex_stall) begin
            action_s = ACT_HOLD;
        end else if (hazard_s) begin
            action_s    = ACT_BUBBLE;
            count_inc_s = 1'b1;
        end else begin
            action_s = ACT_LOAD;
        end
    end

    // A redirect makes IF refetch, so it never freezes the front end.
    assign hazard_stall = ~ex_redirect & (ex_stall | hazard_s);

    // ID/EX register bank and bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r    <= 1'b0;
            ex_ctrl_r     <= BUBBLE_CTRL;
            ex_pc_r       <= '0;
            ex_rs1_data_r <= '0;
            ex_rs2_data_r <= '0;
            ex_imm_r      <= '0;
            ex_rs1_r      <= 5'd0;
            ex_rs2_r      <= 5'd0;
            ex_rd_r       <= 5'd0;
            ex_funct3_r   <= 3'd0;
            ex_funct7b5_r <= 1'b0;
            bubble_cnt_r  <= '0;
        end else begin
            case (action_s)
                ACT_BUBBLE: begin
                    ex_valid_r <= 1'b0;
                    ex_ctrl_r  <= BUBBLE_CTRL;
                end
                ACT_LOAD: begin
                    ex_valid_r    <= id_valid;
                    ex_ctrl_r     <= id_ctrl_s;
                    ex_pc_r       <= id_pc;
                    ex_rs1_data_r <= id_rs1_data;
                    ex_rs2_data_r <= id_rs2_data;
                    ex_imm_r      <= id_imm;
                    ex_rs1_r      <= id_rs1;
                    ex_rs2_r      <= id_rs2;
                    ex_rd_r       <= id_rd;
                    ex_funct3_r   <= id_funct3;
                    ex_funct7b5_r <= id_funct7b5;
                end
                default: begin
                    ex_valid_r <= ex_valid_r;
                end
            endcase
            if (count_inc_s && (bubble_cnt_r != CNT_MAX)) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end
    end

    assign ex_valid    = ex_valid_r;
    assign ex_ALU_op   = ex_ctrl_r.alu_op;
    assign ex_DMtoReg  = ex_ctrl_r.dm_to_reg;
    assign ex_RegWrite = ex_ctrl_r.reg_write;
    assign ex_DM_en    = ex_ctrl_r.dm_en;
    assign ex_DM_write = ex_ctrl_r.dm_write;
    assign ex_jump     = ex_ctrl_r.jump;
    assign ex_branch   = ex_ctrl_r.branch;
    assign ex_ALU_src  = ex_ctrl_r.alu_src;
    assign ex_auipc    = ex_ctrl_r.auipc;
    assign ex_pc       = ex_pc_r;
    assign ex_rs1_data = ex_rs1_data_r;
    assign ex_rs2_data = ex_rs2_data_r;
    assign ex_imm      = ex_imm_r;
    assign ex_rs1      = ex_rs1_r;
    assign ex_rs2      = ex_rs2_r;
    assign ex_rd       = ex_rd_r;
    assign ex_funct3   = ex_funct3_r;
    assign ex_funct7b5 = ex_funct7b5_r;
    assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage RV32I core: captures the control word from the instruction decoder plus the decoded operands, and presents them to EX one cycle later. It also detects load-use hazards against the instruction currently in EX, inserting bubbles and stalling IF/ID. Branch or jump redirects from EX flush it. It sits between the main decoder/register-file read (ID) and the ALU/branch unit (EX).

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of the bubble performance counter

Ports (control inputs use the decoder's encodings: ALU_op 00 R, 01 I, 10 load/store/branch, 11 other; DMtoReg 00 imm, 01 pc+4, 10 alu, 11 dm):
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_op  in  7  opcode of ID instruction
- id_ALU_op, id_DMtoReg  in  2 each  decoder outputs
- id_RegWrite, id_DM_en, id_DM_write, id_jump, id_branch, id_ALU_src, id_auipc  in  1 each  decoder outputs
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands
- id_rs1, id_rs2, id_rd  in  5 each  register addresses
- id_funct3  in  3;  id_funct7b5  in  1
- ex_stall  in  1  downstream (MEM) busy; hold EX contents
- ex_redirect  in  1  taken branch/jump resolved in EX
- ex_* outputs  out  same widths as id_* counterparts (valid, control, operands, addresses, funct fields)
- hazard_stall  out  1  combinational; freeze PC and IF/ID
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

## Operation
- Next-state priority per clock edge: rst > ex_redirect > ex_stall > hazard > normal load.
- rst: ex_valid=0, all ex_ control bits 0, ex_ALU_op=11, ex_DMtoReg=00, ex_ALU_src=1, data/addr fields 0, bubble_cnt=0.
- ex_redirect: load bubble (ex_valid=0, RegWrite/DM_en/DM_write/jump/branch/auipc=0); ID instruction discarded. Overrides ex_stall.
- ex_stall (no redirect): all ex_* hold; hazard_stall forced 1 so IF/ID also hold.
- Load-use hazard: ex_valid & ex_DM_en & ~ex_DM_write & ex_RegWrite & ex_rd!=0 & id_valid & ((rs1_used & id_rs1==ex_rd) | (rs2_used & id_rs2==ex_rd)).
  - rs1_used: op not in {LUI, AUIPC, JAL}. rs2_used: op in {R, STORE, BRANCH}.
  - Hazard: load bubble, hazard_stall=1, bubble_cnt+1. Bubble clears the condition next cycle, so exactly one bubble per load-use pair.
- Normal: all id_* captured; ex_valid=id_valid. When id_valid=0 control bits are zeroed as for a bubble.
- bubble_cnt increments only on hazard bubbles, saturates at 2^CNT_W-1; redirect bubbles not counted.
- x0 never causes a hazard.

## Timing
- Latency 1 cycle ID -> EX.
- hazard_stall purely combinational from current ex_* and id_* (same cycle); no registered path.
- Simultaneous hazard and redirect: redirect wins, no count, hazard_stall deasserted (IF refetches).
- Reset mid-stall clears everything next edge; hazard_stall 0 the cycle after reset.
- ex_stall held N cycles: ex_* identical for N edges; load resumes first edge after deassert.

## Structure
- Shared package riscv_pkg: opcode constants (R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), ALU_op/DMtoReg encodings, packed struct ctrl_t of the nine decoder outputs, BUBBLE_CTRL constant (the reset/bubble control value).
- One sub-module: load_use_detect (combinational hazard equation incl. rs_used decode); register bank in id_ex_stage.

## Test plan
- Reset: assert rst 2 cycles with random inputs -> ex_valid=0, ex_RegWrite=0, ex_ALU_op=11, bubble_cnt=0.
- Pass-through: R-type add x3,x1,x2 (pc=0x100) -> next cycle ex_valid=1, ex_ALU_op=00, ex_DMtoReg=10, ex_rd=3, ex_pc=0x100.
- Load-use: lw x5 in EX, ID add x6,x5,x1 -> hazard_stall=1 same cycle, one bubble, add enters EX next cycle, bubble_cnt=1; repeat with rd=x0 or ID=LUI x5 -> no stall.
- Redirect vs hazard: both true same cycle -> bubble, hazard_stall=0, bubble_cnt unchanged.
- ex_stall 3 cycles with changing id_* -> ex_* constant 3 edges, then load ID values.
- Saturation: CNT_W=2, 5 load-use pairs -> bubble_cnt stops at 3.
